// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and round-robin pick for the UART TX arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {ARB, HEADER, PASS, RELEASE} UART_ARB_SM;

  localparam byte UART_ARB_HEADER_BASE = 8'hA0;
  localparam int  UART_ARB_MAX_REQ     = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan starts one past the previous owner so it becomes lowest priority.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] last,
                                       input int n);
    rr_pick_t r;
    int i;
    r = '0;
    for (int k = 1; k <= UART_ARB_MAX_REQ; k++) begin
      i = (int'(last) + k) % n;
      if (k <= n && !r.valid && req[i[2:0]]) begin
        r.valid = 1'b1;
        r.idx   = i[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART-core signals of the TX arbiter
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   send_byte;
  logic [8*N_REQ-1:0] tx_byte;
  logic [N_REQ-1:0]   tx_active;
  logic [N_REQ-1:0]   grant;
  logic               dropped;
  logic               uart_tx_send_byte;
  logic [7:0]         uart_tx_byte;
  logic               uart_tx_active;

  modport master (
    output req, send_byte, tx_byte, uart_tx_active,
    input  tx_active, grant, dropped, uart_tx_send_byte, uart_tx_byte
  );

  modport slave (
    input  req, send_byte, tx_byte, uart_tx_active,
    output tx_active, grant, dropped, uart_tx_send_byte, uart_tx_byte
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-held sharing of one UART TX byte port
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          N_REQ     = 4,
  parameter bit          HEADER_EN = 1'b1,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic             clock,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  UART_ARB_SM       state;
  logic [2:0]       owner;
  logic [2:0]       last;
  logic [N_REQ-1:0] grant_q;
  logic [1:0]       guard;
  logic [15:0]      idle;
  logic             send_q;
  logic [7:0]       byte_q;
  logic             dropped_q;

  logic             owner_send;
  logic             owner_req;
  logic             can_send;
  logic             fwd;
  logic [N_REQ-1:0] fwd_mask;
  logic [7:0]       owner_byte;
  logic [15:0]      idle_next;
  rr_pick_t         pick;

  always_comb begin
    owner_send = |(bus.send_byte & grant_q);
    owner_req  = |(bus.req & grant_q);
    can_send   = !bus.uart_tx_active && (guard == 2'd0);
    fwd        = (state == PASS) && owner_send && can_send;
    fwd_mask   = fwd ? grant_q : '0;
    idle_next  = idle + 16'd1;
    pick       = rr_pick(8'(bus.req), last, N_REQ);
    owner_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == 3'(i)) owner_byte = bus.tx_byte[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB;
      owner     <= '0;
      last      <= 3'(N_REQ - 1);
      grant_q   <= '0;
      guard     <= '0;
      idle      <= '0;
      send_q    <= 1'b0;
      byte_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      send_q    <= 1'b0;
      dropped_q <= |(bus.send_byte & ~fwd_mask);
      if (guard != 2'd0) guard <= guard - 2'd1;

      case (state)
        ARB: begin
          if (pick.valid) begin
            owner   <= pick.idx;
            last    <= pick.idx;
            grant_q <= N_REQ'(1) << pick.idx;
            idle    <= '0;
            state   <= HEADER_EN ? HEADER : PASS;
          end
        end
        HEADER: begin
          if (can_send) begin
            send_q <= 1'b1;
            byte_q <= UART_ARB_HEADER_BASE | {5'b0, owner};
            guard  <= 2'd2;
            state  <= PASS;
          end
        end
        PASS: begin
          if (fwd) begin
            send_q <= 1'b1;
            byte_q <= owner_byte;
            guard  <= 2'd2;
            idle   <= '0;
          end else begin
            idle <= idle_next;
          end
          // A byte sent alongside the req drop is still forwarded above.
          if (!owner_req || (!fwd && idle_next == TIMEOUT - 16'd1)) state <= RELEASE;
        end
        RELEASE: begin
          grant_q <= '0;
          state   <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.grant             = grant_q;
  assign bus.uart_tx_send_byte = send_q;
  assign bus.uart_tx_byte      = byte_q;
  assign bus.dropped           = dropped_q;
  assign bus.tx_active         = ~({N_REQ{state == PASS}} & grant_q)
                               | {N_REQ{bus.uart_tx_active || (guard != 2'd0)}};

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.N_REQ(4)) bus ();

  uart_tx_arbiter #(.N_REQ(4), .HEADER_EN(1'b1), .TIMEOUT(16'd16)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // UART core: goes busy the cycle after a send, for 10 cycles.
  int         busy  = 0;
  int         drops = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  assign bus.uart_tx_active = (busy != 0);

  always @(posedge clock) begin
    if (bus.uart_tx_send_byte) begin
      cap.push_back(bus.uart_tx_byte);
      busy <= 10;
    end else if (busy != 0) begin
      busy <= busy - 1;
    end
    if (bus.dropped) drops <= drops + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int base);
    check({tag, "_count"}, cap.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_%0d", tag, i),
            (base + i < cap.size()) ? {24'h0, cap[base+i]} : 32'hDEAD, {24'h0, exp_q[i]});
  endtask

  task automatic wait_free(input int i);
    int n = 0;
    while (bus.tx_active[i] !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("wait_free_timeout", 0, 1);
  endtask

  task automatic wait_grant(input logic nonzero);
    int n = 0;
    while (((bus.grant != 0) != nonzero) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("wait_grant_timeout", 0, 1);
  endtask

  task automatic send_req(input int i, input logic [7:0] b);
    wait_free(i);
    bus.tx_byte[8*i +: 8] = b;
    bus.send_byte[i] = 1'b1;
    @(negedge clock);
    bus.send_byte[i] = 1'b0;
  endtask

  function automatic int owner_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  int base;
  int d0;
  int o;

  initial begin
    reset = 1'b1;
    bus.req = '0;
    bus.send_byte = '0;
    bus.tx_byte = '0;
    repeat (3) @(negedge clock);
    check("rst_grant", bus.grant, 0);
    check("rst_tx_active", bus.tx_active, 4'hF);
    check("rst_send", bus.uart_tx_send_byte, 0);
    check("rst_byte", bus.uart_tx_byte, 0);
    check("rst_dropped", bus.dropped, 0);
    reset = 1'b0;
    @(negedge clock);

    // Single requester, three bytes.
    base = cap.size(); d0 = drops;
    bus.req[1] = 1'b1;
    @(negedge clock);
    check("single_grant_latency", bus.grant, 4'b0010);
    send_req(1, 8'h11);
    send_req(1, 8'h22);
    send_req(1, 8'h33);
    bus.req[1] = 1'b0;
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    exp_q = {8'hA1, 8'h11, 8'h22, 8'h33};
    check_bytes("single", base);
    check("single_drops", drops - d0, 0);

    // Rotation from reset: 0,1,2,3.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    base = cap.size();
    bus.req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1'b1);
      o = owner_of(bus.grant);
      send_req(o, 8'(8'h40 + o));
      bus.req[o] = 1'b0;
      wait_grant(1'b0);
    end
    exp_q = {8'hA0, 8'h40, 8'hA1, 8'h41, 8'hA2, 8'h42, 8'hA3, 8'h43};
    check_bytes("rotate", base);

    // Owner 2 alone, then all request: 3 must come next.
    bus.req = 4'b0100;
    wait_grant(1'b1);
    send_req(2, 8'h52);
    bus.req = '0;
    wait_grant(1'b0);
    base = cap.size();
    bus.req = 4'hF;
    wait_grant(1'b1);
    check("rotate_after_2", bus.grant, 4'b1000);
    send_req(3, 8'h63);
    bus.req = '0;
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    exp_q = {8'hA3, 8'h63};
    check_bytes("rotate_repeat", base);

    // Non-owner send is dropped.
    base = cap.size(); d0 = drops;
    bus.req = 4'b0001;
    wait_grant(1'b1);
    wait_free(0);
    bus.tx_byte[23:16] = 8'hEE;
    bus.send_byte[2] = 1'b1;
    @(negedge clock);
    bus.send_byte[2] = 1'b0;
    bus.req = '0;
    check("drop_pulse", bus.dropped, 1);
    @(negedge clock);
    check("drop_clear", bus.dropped, 0);
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    check("drop_count", drops - d0, 1);
    exp_q = {8'hA0};
    check_bytes("drop", base);

    // Owner send inside the guard window is dropped.
    base = cap.size(); d0 = drops;
    bus.req = 4'b0001;
    wait_grant(1'b1);
    send_req(0, 8'h77);
    check("guard_fwd_pulse", bus.uart_tx_send_byte, 1);
    check("guard_owner_busy", bus.tx_active[0], 1);
    bus.tx_byte[7:0] = 8'h78;
    bus.send_byte[0] = 1'b1;
    @(negedge clock);
    bus.send_byte[0] = 1'b0;
    bus.req = '0;
    check("guard_drop", bus.dropped, 1);
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    check("guard_drop_count", drops - d0, 1);
    exp_q = {8'hA0, 8'h77};
    check_bytes("guard", base);

    // Idle owner times out; next requester is granted with its header.
    base = cap.size();
    bus.req = 4'b0011;
    @(negedge clock);
    check("tmo_grant1", bus.grant, 4'b0010);
    begin
      int n = 0;
      while (bus.uart_tx_send_byte !== 1'b1 && n < 50) begin
        @(negedge clock);
        n++;
      end
      if (n >= 50) check("tmo_header_timeout", 0, 1);
    end
    repeat (15) @(negedge clock);
    check("tmo_cycle16_held", bus.grant, 4'b0010);
    @(negedge clock);
    check("tmo_cleared", bus.grant, 0);
    @(negedge clock);
    check("tmo_next_grant", bus.grant, 4'b0001);
    @(negedge clock);
    check("tmo_hdr_send", bus.uart_tx_send_byte, 1);
    check("tmo_hdr_byte", bus.uart_tx_byte, 8'hA0);
    bus.req = '0;
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    exp_q = {8'hA1, 8'hA0};
    check_bytes("tmo", base);

    // Reset in PASS aborts the pending send; arbitration restarts at 0.
    base = cap.size();
    bus.req = 4'b0100;
    wait_grant(1'b1);
    wait_free(2);
    bus.tx_byte[23:16] = 8'h99;
    bus.send_byte[2] = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.send_byte[2] = 1'b0;
    bus.req = 4'b1001;
    check("rstmid_grant", bus.grant, 0);
    check("rstmid_tx_active", bus.tx_active, 4'hF);
    check("rstmid_send", bus.uart_tx_send_byte, 0);
    @(negedge clock);
    check("rstmid_regrant", bus.grant, 4'b0001);
    bus.req = '0;
    wait_grant(1'b0);
    repeat (14) @(negedge clock);
    exp_q = {8'hA2, 8'hA0};
    check_bytes("rstmid", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
